// File: rtl/neuraedge_noc_pkg.sv
// Shared NoC definitions: flit type encoding, head-flit field positions and
// the injector FSM state encoding.
package neuraedge_noc_pkg;

  typedef enum logic [1:0] {
    FT_BODY     = 2'b00,
    FT_HEAD     = 2'b01,
    FT_TAIL     = 2'b10,
    FT_HEADTAIL = 2'b11
  } flit_type_e;

  // Head-flit field positions (64-bit flit, type in the top two bits).
  localparam int DST_W       = 4;
  localparam int HDR_ROW_LSB = 58;
  localparam int HDR_COL_LSB = 54;
  localparam int HDR_LEN_LSB = 46;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BODY  = 2'b01,
    ST_DRAIN = 2'b10
  } inj_state_e;

endpackage

// File: rtl/ext_pkt_injector.sv
// Host-side wormhole packet injector feeding the external NoC flit input.
// Optional destination range check is built when NEURAEDGE_INJ_DSTCHK_EN is defined.
module ext_pkt_injector
  import neuraedge_noc_pkg::*;
#(
  parameter int FLIT_W = 64,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int LEN_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [3:0]          cmd_dst_row,
  input  logic [3:0]          cmd_dst_col,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                data_valid,
  output logic                data_ready,
  input  logic [FLIT_W-3:0]   data_word,
  output logic [FLIT_W-1:0]   flit_out,
  output logic                valid_out,
  input  logic                ready_in,
  output logic                busy,
  output logic [15:0]         pkt_count,
  output logic                err_dst
);

  inj_state_e         state, state_n;
  logic [LEN_W-1:0]   cnt, cnt_n;
  logic [FLIT_W-1:0]  head_flit, flit_n;
  logic               ld, load, pkt_inc;
  logic               cmd_fire, data_fire, dst_bad;

  // The output register may take a new flit when empty or draining this cycle.
  assign ld         = !valid_out || ready_in;
  assign cmd_ready  = (state == ST_IDLE) && ld;
  assign data_ready = ((state == ST_BODY) && ld) || (state == ST_DRAIN);
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign data_fire  = data_valid && data_ready;
  assign busy       = (state != ST_IDLE) || valid_out;

`ifdef NEURAEDGE_INJ_DSTCHK_EN
  assign dst_bad = (int'(cmd_dst_row) >= ROWS) || (int'(cmd_dst_col) >= COLS);
  assign err_dst = cmd_fire && dst_bad;
`else
  assign dst_bad = 1'b0;
  assign err_dst = 1'b0;
`endif

  always_comb begin
    head_flit                          = '0;
    head_flit[FLIT_W-1 -: 2]           = (cmd_len == '0) ? FT_HEADTAIL : FT_HEAD;
    head_flit[HDR_ROW_LSB +: DST_W]    = cmd_dst_row;
    head_flit[HDR_COL_LSB +: DST_W]    = cmd_dst_col;
    head_flit[HDR_LEN_LSB +: LEN_W]    = cmd_len;
  end

  // NOTE: every output of this block is defaulted first so no path infers a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    flit_n  = '0;
    load    = 1'b0;
    pkt_inc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_fire && !dst_bad) begin
          load   = 1'b1;
          flit_n = head_flit;
          cnt_n  = cmd_len;
          if (cmd_len == '0) pkt_inc = 1'b1;
          else               state_n = ST_BODY;
        end
`ifdef NEURAEDGE_INJ_DSTCHK_EN
        else if (cmd_fire) begin
          cnt_n = cmd_len;
          if (cmd_len != '0) state_n = ST_DRAIN;
        end
`endif
      end
      ST_BODY: begin
        if (data_fire) begin
          load  = 1'b1;
          cnt_n = cnt - LEN_W'(1);
          if (cnt == LEN_W'(1)) begin
            flit_n  = {FT_TAIL, data_word};
            state_n = ST_IDLE;
            pkt_inc = 1'b1;
          end else begin
            flit_n = {FT_BODY, data_word};
          end
        end
      end
`ifdef NEURAEDGE_INJ_DSTCHK_EN
      ST_DRAIN: begin
        if (data_fire) begin
          cnt_n = cnt - LEN_W'(1);
          if (cnt == LEN_W'(1)) state_n = ST_IDLE;
        end
      end
`endif
      default: state_n = ST_IDLE;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      valid_out <= 1'b0;
      flit_out  <= '0;
      pkt_count <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (ld) begin
        valid_out <= load;
        if (load) flit_out <= flit_n;
      end
      if (pkt_inc) pkt_count <= pkt_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_ext_pkt_injector.sv
// Directed self-checking bench for ext_pkt_injector; builds the destination
// check test when NEURAEDGE_INJ_DSTCHK_EN is defined.
module tb_ext_pkt_injector;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_dst_row, cmd_dst_col;
  logic [7:0]  cmd_len;
  logic        data_valid, data_ready;
  logic [61:0] data_word;
  logic [63:0] flit_out;
  logic        valid_out, ready_in, busy, err_dst;
  logic [15:0] pkt_count;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_err    = 0;
  int n_words  = 0;
  logic [63:0] flits[$];
  int          fcyc[$];

  ext_pkt_injector dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dst_row(cmd_dst_row), .cmd_dst_col(cmd_dst_col), .cmd_len(cmd_len),
    .data_valid(data_valid), .data_ready(data_ready), .data_word(data_word),
    .flit_out(flit_out), .valid_out(valid_out), .ready_in(ready_in),
    .busy(busy), .pkt_count(pkt_count), .err_dst(err_dst)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Handshakes are stable from the falling edge to the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_out && ready_in) begin
        flits.push_back(flit_out);
        fcyc.push_back(cyc);
      end
      if (err_dst) n_err++;
      if (data_valid && data_ready) n_words++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [3:0] r, input logic [3:0] c, input logic [7:0] l);
    int n = 0;
    cmd_valid = 1'b1; cmd_dst_row = r; cmd_dst_col = c; cmd_len = l;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check("cmd_wait", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_word(input logic [61:0] w);
    int n = 0;
    data_valid = 1'b1; data_word = w;
    @(negedge clk);
    while (!data_ready && n < 50) begin @(negedge clk); n++; end
    check("data_wait", {63'd0, data_ready}, 64'd1);
    @(posedge clk); #1;
    data_valid = 1'b0;
  endtask

  task automatic clear_mon();
    flits.delete(); fcyc.delete();
    n_err = 0; n_words = 0;
  endtask

  task automatic check_flits(input string tag, input logic [63:0] exp[$]);
    check({tag, "_count"}, 64'(flits.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < flits.size(); i++)
      check($sformatf("%s_flit%0d", tag, i), flits[i], exp[i]);
    if (flits.size() == exp.size() && exp.size() > 1)
      check({tag, "_consec"}, 64'(fcyc[fcyc.size()-1] - fcyc[0]), 64'(exp.size() - 1));
  endtask

  initial begin
    logic [15:0] pc0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_dst_row = '0; cmd_dst_col = '0; cmd_len = '0;
    data_valid = 1'b0; data_word = '0; ready_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_valid_out",  {63'd0, valid_out},  64'd0);
    check("rst_flit_out",   flit_out,            64'd0);
    check("rst_cmd_ready",  {63'd0, cmd_ready},  64'd1);
    check("rst_data_ready", {63'd0, data_ready}, 64'd0);
    check("rst_busy",       {63'd0, busy},       64'd0);
    check("rst_pkt_count",  {48'd0, pkt_count},  64'd0);
    check("rst_err_dst",    {63'd0, err_dst},    64'd0);

    // Single-flit packet
    clear_mon();
    send_cmd(4'd2, 4'd1, 8'd0);
    idle(4);
    check_flits("single", '{64'hC840_0000_0000_0000});
    check("single_pkt_count", {48'd0, pkt_count}, 64'd1);

    // Streaming len=3
    clear_mon();
    send_cmd(4'd3, 4'd3, 8'd3);
    send_word(62'h1);
    send_word(62'h2);
    send_word(62'h3);
    idle(4);
    check_flits("stream", '{64'h4CC0_C000_0000_0000, 64'h1, 64'h2, 64'h8000_0000_0000_0003});
    check("stream_pkt_count", {48'd0, pkt_count}, 64'd2);

    // Backpressure mid-body
    clear_mon();
    send_cmd(4'd0, 4'd2, 8'd4);
    send_word(62'h0AAA);
    ready_in = 1'b0; data_valid = 1'b1; data_word = 62'h0BBB;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_flit_hold%0d", i), flit_out, 64'h0AAA);
      check($sformatf("bp_data_ready%0d", i), {63'd0, data_ready}, 64'd0);
      check($sformatf("bp_valid%0d", i), {63'd0, valid_out}, 64'd1);
    end
    @(posedge clk); #1;
    ready_in = 1'b1;
    send_word(62'h0BBB);
    send_word(62'h0CCC);
    send_word(62'h3FFF_FFFF_FFFF_FFFF);
    idle(4);
    check("bp_count", 64'(flits.size()), 64'd5);
    if (flits.size() == 5) begin
      check("bp_head", flits[0], 64'h4081_0000_0000_0000);
      check("bp_b0",   flits[1], 64'h0000_0000_0000_0AAA);
      check("bp_b1",   flits[2], 64'h0000_0000_0000_0BBB);
      check("bp_b2",   flits[3], 64'h0000_0000_0000_0CCC);
      check("bp_tail", flits[4], 64'hBFFF_FFFF_FFFF_FFFF);
    end
    check("bp_pkt_count", {48'd0, pkt_count}, 64'd3);

    // Back-to-back len=1 packets
    clear_mon();
    pc0 = pkt_count;
    send_cmd(4'd1, 4'd0, 8'd1);
    send_word(62'h55);
    send_cmd(4'd1, 4'd1, 8'd1);
    send_word(62'h66);
    idle(4);
    check_flits("b2b", '{64'h4400_4000_0000_0000, 64'h8000_0000_0000_0055,
                         64'h4440_4000_0000_0000, 64'h8000_0000_0000_0066});
    check("b2b_pkt_delta", {48'd0, pkt_count - pc0}, 64'd2);

`ifdef NEURAEDGE_INJ_DSTCHK_EN
    // Out-of-range destination is swallowed along with its payload
    clear_mon();
    pc0 = pkt_count;
    send_cmd(4'd5, 4'd0, 8'd2);
    send_word(62'h77);
    send_word(62'h88);
    idle(4);
    check("dst_err_pulses", 64'(n_err), 64'd1);
    check("dst_words",      64'(n_words), 64'd2);
    check("dst_flits",      64'(flits.size()), 64'd0);
    check("dst_pkt_count",  {48'd0, pkt_count}, {48'd0, pc0});
    check("dst_idle",       {63'd0, cmd_ready}, 64'd1);
`else
    // Without the check the head is emitted as given
    clear_mon();
    send_cmd(4'd5, 4'd0, 8'd0);
    idle(4);
    check_flits("nochk", '{64'hD400_0000_0000_0000});
    check("nochk_err", 64'(n_err), 64'd0);
`endif

    // Reset mid-packet
    send_cmd(4'd2, 4'd2, 8'd3);
    send_word(62'h7);
    check("mid_busy_before", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_valid_out", {63'd0, valid_out}, 64'd0);
    check("mid_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("mid_busy",      {63'd0, busy},      64'd0);
    check("mid_pkt_count", {48'd0, pkt_count}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
